// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory signals of the shared 16-bit bus arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_bus_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [15:0] addr0;
   logic [15:0] addr1;
   logic [15:0] wdata0;
   logic [15:0] wdata1;
   logic        gnt0;
   logic        gnt1;
   logic        done0;
   logic        done1;
   logic        err;
   logic [15:0] rdata;
   logic        busy;
   logic [15:0] memAddr;
   logic [15:0] memDataOut;
   logic [15:0] memDataIn;
   logic        read;
   logic        write;
   logic        MFC;

   modport master (
      input  req0, req1, we0, we1,
      input  addr0, addr1, wdata0, wdata1,
      input  memDataIn, MFC,
      output gnt0, gnt1, done0, done1, err,
      output rdata, busy,
      output memAddr, memDataOut, read, write
   );

   modport slave (
      output req0, req1, we0, we1,
      output addr0, addr1, wdata0, wdata1,
      output memDataIn, MFC,
      input  gnt0, gnt1, done0, done1, err,
      input  rdata, busy,
      input  memAddr, memDataOut, read, write
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-port arbiter and sequencer for the shared memory bus.
// Every output comes straight from a flop; MFC or timeout ends a transaction.
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic             clock,
   input logic             reset,
   mem_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef struct packed {
      logic        gnt0;
      logic        gnt1;
      logic        done0;
      logic        done1;
      logic        err;
      logic        busy;
      logic        read;
      logic        write;
      logic [15:0] mem_addr;
      logic [15:0] mem_data_out;
      logic [15:0] rdata;
   } out_t;

   localparam logic [3:0] CNT_MAX = 4'(TIMEOUT_CYCLES - 1);

   state_t     state, state_nx;
   out_t       o_q, o_nx;
   logic [3:0] cnt, cnt_nx;
   logic       last_gnt, last_gnt_nx;
   logic       port, port_nx;
   logic       pick;

   // State, owner, timeout counter and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         o_q      <= '0;
         cnt      <= '0;
         last_gnt <= 1'b1;
         port     <= 1'b0;
      end else begin
         state    <= state_nx;
         o_q      <= o_nx;
         cnt      <= cnt_nx;
         last_gnt <= last_gnt_nx;
         port     <= port_nx;
      end
   end

   // Arbitration, transaction sequencing and next output values.
   always_comb begin
      state_nx    = state;
      o_nx        = o_q;
      cnt_nx      = cnt;
      last_gnt_nx = last_gnt;
      port_nx     = port;
      pick        = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               // On a tie the port not served last wins.
               pick = (bus.req0 & bus.req1) ? ~last_gnt : bus.req1;
               port_nx           = pick;
               last_gnt_nx       = pick;
               cnt_nx            = '0;
               o_nx.mem_addr     = pick ? bus.addr1 : bus.addr0;
               o_nx.mem_data_out = pick ? bus.wdata1 : bus.wdata0;
               o_nx.write        = pick ? bus.we1 : bus.we0;
               o_nx.read         = ~(pick ? bus.we1 : bus.we0);
               o_nx.gnt0         = ~pick;
               o_nx.gnt1         = pick;
               o_nx.busy         = 1'b1;
               state_nx          = BUSY;
            end
         end
         BUSY: begin
            if (bus.MFC || cnt == CNT_MAX) begin
               // MFC beats a coincident timeout.
               if (bus.MFC && o_q.read) o_nx.rdata = bus.memDataIn;
               o_nx.err   = ~bus.MFC;
               o_nx.read  = 1'b0;
               o_nx.write = 1'b0;
               o_nx.gnt0  = 1'b0;
               o_nx.gnt1  = 1'b0;
               o_nx.done0 = ~port;
               o_nx.done1 = port;
               state_nx   = DONE;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         DONE: begin
            o_nx.done0 = 1'b0;
            o_nx.done1 = 1'b0;
            o_nx.err   = 1'b0;
            o_nx.busy  = 1'b0;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.gnt0       = o_q.gnt0;
   assign bus.gnt1       = o_q.gnt1;
   assign bus.done0      = o_q.done0;
   assign bus.done1      = o_q.done1;
   assign bus.err        = o_q.err;
   assign bus.busy       = o_q.busy;
   assign bus.read       = o_q.read;
   assign bus.write      = o_q.write;
   assign bus.memAddr    = o_q.mem_addr;
   assign bus.memDataOut = o_q.mem_data_out;
   assign bus.rdata      = o_q.rdata;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer for the single shared 16-bit memory bus of the CPU. Port 0 serves instruction fetch, port 1 serves stack push/pop and call/return traffic. The block accepts level requests, picks a winner by round-robin, and drives `memAddr`/`memDataOut`/`read`/`write`. It then waits for the memory's MFC acknowledge, returns read data, and signals completion or a timeout error to the winning requester.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 15: max BUSY cycles without MFC before abort; legal 1..15 (4-bit counter).

Ports (one clock; reset is synchronous, active-high):
- `clock` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req0` / `req1` in 1: level request, port 0 / port 1.
- `we0` / `we1` in 1: 1 = write, 0 = read; sampled at grant edge.
- `addr0` / `addr1` in 16: address; sampled at grant edge.
- `wdata0` / `wdata1` in 16: write data; sampled at grant edge.
- `gnt0` / `gnt1` out 1: high for the whole BUSY phase of that port's transaction.
- `done0` / `done1` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse coincident with `doneX` when the transaction timed out.
- `rdata` out 16: read data captured on MFC; shared by both ports; holds until the next successful read.
- `busy` out 1: high in BUSY and DONE.
- `memAddr` out 16: latched address to memory.
- `memDataOut` out 16: latched write data to memory.
- `memDataIn` in 16: read data from memory.
- `read` / `write` out 1: memory strobes.
- `MFC` in 1: memory function complete, level, sampled only in BUSY.

## Operation
- All outputs are registered.
- States:
  - IDLE (reset)
  - BUSY
  - DONE
- **IDLE:**
  - No request: stay; all strobes 0.
  - Exactly one `reqX`: grant X.
  - Both requesting: grant the port not granted last. `lastGnt` resets to 1, so port 0 wins the first tie.
- **On grant (IDLE→BUSY edge):**
  - Latch `memAddr`←`addrX` and `memDataOut`←`wdataX` (for reads `memDataOut` is still loaded and ignored).
  - `read`←~`weX`, `write`←`weX`, `gntX`←1.
  - `lastGnt`←X, `cnt`←0.
- **BUSY, each edge:**
  - `MFC`=1: `rdata`←`memDataIn` (reads only), strobes←0, `gntX`←0, `doneX`←1, go to DONE.
  - Else if `cnt`==`TIMEOUT_CYCLES`-1: strobes←0, `gntX`←0, `doneX`←1, `err`←1, `rdata` unchanged, go to DONE.
  - Else `cnt`←`cnt`+1.
- **DONE:**
  - Lasts one cycle. `doneX`/`err` clear on exit; go to IDLE.
  - A `reqX` still high in IDLE starts a new transaction. Requesters drop `req` in the cycle they observe `doneX`, unless they want another transaction.
- Request inputs are ignored outside IDLE.
- `addr`/`we`/`wdata` are only required to be stable at the grant edge.
- Arithmetic: `cnt` is 4-bit unsigned. No addition is performed on address or data.

## Timing
- Reset values: state IDLE, `lastGnt`=1, `cnt`=0. Every output is 0: `gnt*`, `done*`, `err`, `busy`, `read`, `write`, `memAddr`, `memDataOut`, `rdata`.
- Minimum transaction, request high before edge k:
  - Grant/strobe visible after edge k.
  - MFC sampled at edge k+1 → `done` visible after k+1.
  - IDLE after k+2.
  - Three cycles total per transaction.
- Back-to-back requests on the same port: next grant at edge k+3.
- MFC and timeout on the same edge: MFC wins, no `err`.
- Timeout: `err`/`done` visible after the (k+`TIMEOUT_CYCLES`)th edge.
- MFC high in IDLE or DONE: ignored. A stale MFC still high at the next grant is accepted at that transaction's first BUSY edge. Memory deasserts MFC when the strobe drops.
- Reset asserted in any state: next edge forces the reset values. An in-flight transaction is dropped with no `done`.

## Test plan
- **Single read, port 0:** `req0`=1, `we0`=0, `addr0`=0x0010; MFC=1 two cycles after grant with `memDataIn`=0xF440.
  - `read` and `gnt0` high for 3 cycles, `memAddr`=0x0010.
  - `done0` pulses once, `rdata`=0xF440, `err`=0.
- **Single write, port 1:** `we1`=1, `addr1`=0xFFFE, `wdata1`=0x1234; immediate MFC.
  - `write`=1 for 1 cycle, `memDataOut`=0x1234.
  - `done1` 3 cycles after request, `rdata` unchanged.
- **Contention:** `req0` and `req1` held high together for 4 transactions.
  - Grants alternate 0,1,0,1 starting with port 0, never overlapping.
- **Timeout:** `TIMEOUT_CYCLES`=4, MFC never asserted.
  - `read` high exactly 4 cycles, then `done0` and `err` both pulse.
  - `rdata` keeps its prior value. The next request proceeds normally.
- **MFC/timeout collision:** MFC arrives on the final BUSY edge.
  - `done` without `err`, `rdata` captured.
- **Reset mid-op:** `reset` pulsed during BUSY.
  - All outputs 0 next cycle, no `done`.
  - After release, a simultaneous `req0`/`req1` grants port 0 first.
